// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, response codes and default parameters for the cache request master.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_SAMPLE, RESP} state_t;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: power-of-two depth command FIFO with async active-low pointer reset.
module req_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // extra pointer bit distinguishes full from empty when the indices match
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop) rd_ptr <= rd_ptr + ONE;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/cache_req_master.sv
// cache_req_master: queues load/store commands and issues them one at a time to the L1,
// returning a single response per command with a read timeout.
module cache_req_master
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              awvalid,
  output logic              wvalid,
  output logic              arvalid,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              r_hit,
  input  logic              w_hit,
  input  logic [1:0]        r_resp,
  input  logic [1:0]        w_resp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_hit,
  output logic              rsp_timeout
);
  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state, nxt;
  logic [FW-1:0] head;
  logic full, empty, pop, rd_done, rd_expire;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic h_write;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  assign {h_write, h_addr, h_wdata} = head;
  assign cmd_ready = !full;
  req_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(cmd_valid),
    .din({cmd_write, cmd_addr, cmd_wdata}),
    .full(full),
    .pop(pop),
    .dout(head),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  // strobe cycle drives the FIFO head directly; the registered copy holds it afterwards
  always_comb begin
    nxt = state;
    pop = 1'b0;
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    rd_done = state == RD_WAIT && rvalid;
    rd_expire = state == RD_WAIT && !rvalid && cnt == LAST;
    rsp_valid = state == RESP;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        arvalid = !h_write;
        awvalid = h_write;
        wvalid = h_write;
        nxt = h_write ? WR_SAMPLE : RD_WAIT;
      end
      RD_WAIT: nxt = (rd_done || rd_expire) ? RESP : RD_WAIT;
      WR_SAMPLE: nxt = RESP;
      RESP: nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
    data_addr = pop ? h_addr : addr_q;
    wdata = pop ? h_wdata : wdata_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_write <= 1'b0;
      rsp_data <= '0;
      rsp_resp <= OKAY;
      rsp_hit <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt <= (state == RD_WAIT) ? cnt + CW'(1) : '0;
      if (pop) begin
        addr_q <= h_addr;
        wdata_q <= h_wdata;
      end
      if (state == WR_SAMPLE) begin
        rsp_write <= 1'b1;
        rsp_data <= '0;
        rsp_resp <= w_resp;
        rsp_hit <= w_hit;
        rsp_timeout <= 1'b0;
      end else if (rd_done) begin
        rsp_write <= 1'b0;
        rsp_data <= rdata;
        rsp_resp <= r_resp;
        rsp_hit <= r_hit;
        rsp_timeout <= 1'b0;
      end else if (rd_expire) begin
        rsp_write <= 1'b0;
        rsp_data <= '0;
        rsp_resp <= SLVERR;
        rsp_hit <= 1'b0;
        rsp_timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cache_req_master.sv
// tb_cache_req_master: directed vector table plus hand sequences for FIFO fill and mid-read reset.
module tb_cache_req_master;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, data_addr;
  logic [DW-1:0] cmd_wdata = '0, wdata, rdata = '0, rsp_data;
  logic awvalid, wvalid, arvalid, rsp_valid, rsp_write, rsp_hit, rsp_timeout;
  logic rvalid = 1'b0, r_hit = 1'b0, w_hit = 1'b0, rsp_ready = 1'b0;
  logic [1:0] r_resp = 2'b00, w_resp = 2'b00, rsp_resp;
  int vectors = 0;
  int errs = 0;
  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            d;
    logic [DW-1:0] rd;
    logic [1:0]    lresp;
    logic          lhit;
    logic [DW-1:0] e_data;
    logic [1:0]    e_resp;
    logic          e_hit;
    logic          e_to;
  } vec_t;
  vec_t vecs [7];
  cache_req_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .data_addr(data_addr), .wdata(wdata),
    .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid),
    .rvalid(rvalid), .rdata(rdata), .r_hit(r_hit), .w_hit(w_hit),
    .r_resp(r_resp), .w_resp(w_resp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_reset_outputs(input string n);
    chk({n, "_addr_data"}, 64'({data_addr, wdata}), 64'(0));
    chk({n, "_ctl"}, 64'({awvalid, wvalid, arvalid, rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_hit, rsp_timeout}), 64'(0));
    chk({n, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask
  // called at the negedge of the strobe cycle; returns at a negedge in IDLE
  task automatic serve(input vec_t v);
    int lim;
    chk("strobe_ar", 64'(arvalid), 64'(!v.w));
    chk("strobe_aw_w", 64'({awvalid, wvalid}), 64'({v.w, v.w}));
    chk("issue_addr", 64'(data_addr), 64'(v.addr));
    if (v.w) begin
      chk("issue_wdata", 64'(wdata), 64'(v.wd));
      w_resp = v.lresp;
      w_hit = v.lhit;
      rvalid = 1'b1;
      rdata = 32'hFFFF_FFFF;
      r_resp = 2'b11;
      r_hit = 1'b1;
      @(negedge clk);
      chk("strobe_width", 64'({awvalid, wvalid, arvalid}), 64'(0));
      chk("addr_hold", 64'(data_addr), 64'(v.addr));
      chk("wdata_hold", 64'(wdata), 64'(v.wd));
      @(negedge clk);
      rvalid = 1'b0;
    end else begin
      lim = v.d > 0 ? v.d : TO;
      rdata = v.rd;
      r_resp = v.lresp;
      r_hit = v.lhit;
      for (int i = 1; i <= lim; i++) begin
        @(negedge clk);
        if (i == 1) begin
          chk("strobe_width", 64'({awvalid, wvalid, arvalid}), 64'(0));
          chk("addr_hold", 64'(data_addr), 64'(v.addr));
        end
        if (i == lim) chk("early_rsp", 64'(rsp_valid), 64'(0));
        if (i == v.d) rvalid = 1'b1;
      end
      @(negedge clk);
      rvalid = 1'b0;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_write", 64'(rsp_write), 64'(v.w));
    chk("rsp_data", 64'(rsp_data), 64'(v.e_data));
    chk("rsp_resp_hit_to", 64'({rsp_resp, rsp_hit, rsp_timeout}), 64'({v.e_resp, v.e_hit, v.e_to}));
    @(negedge clk);
    chk("rsp_hold", 64'({rsp_valid, rsp_data, rsp_resp}), 64'({1'b1, v.e_data, v.e_resp}));
    chk("no_strobe_in_resp", 64'({awvalid, wvalid, arvalid}), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
  endtask
  task automatic run_txn(input vec_t v);
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr = v.addr;
    cmd_wdata = v.wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    serve(v);
  endtask
  initial begin
    vec_t q;
    vecs[0] = '{1'b0, 20'h00040, 32'h0, 3, 32'hDEAD_BEEF, 2'd0, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 20'h00100, 32'h0, 0, 32'h1357_9BDF, 2'd0, 1'b1, 32'h0, 2'd2, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 20'h00080, 32'h1234_5678, 0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 20'h00200, 32'h0, 64, 32'hCAFE_F00D, 2'd0, 1'b0, 32'hCAFE_F00D, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 20'hFFFFF, 32'hAAAA_5555, 0, 32'h0, 2'd2, 1'b1, 32'h0, 2'd2, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 20'h12345, 32'h0, 1, 32'h0123_4567, 2'd1, 1'b1, 32'h0123_4567, 2'd1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 20'h00ABC, 32'h0, 63, 32'h0F0F_0F0F, 2'd2, 1'b0, 32'h0F0F_0F0F, 2'd2, 1'b0, 1'b0};
    #1 rstn = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 7; k++) run_txn(vecs[k]);
    // store parked in RESP while five loads are offered
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 20'h0ABCD;
    cmd_wdata = 32'h55AA_55AA;
    w_resp = 2'd0;
    w_hit = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("fill_store_rsp", 64'({rsp_valid, rsp_write, rsp_hit}), 64'(3'b111));
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", 64'(cmd_ready), 64'(i < 4));
      chk("fill_no_strobe", 64'({awvalid, wvalid, arvalid}), 64'(0));
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr = 20'h00100 + AW'(i);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("fill_full", 64'({cmd_ready, awvalid, wvalid, arvalid, rsp_valid}), 64'(5'b00001));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      q = '{1'b0, 20'h00100 + AW'(j), 32'h0, 1, 32'hA0 + DW'(j), 2'd0, 1'b0, 32'hA0 + DW'(j), 2'd0, 1'b0, 1'b0};
      serve(q);
    end
    chk("fill_drained", 64'({cmd_ready, arvalid}), 64'(2'b10));
    // reset while a load waits, with a second load still queued
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 20'h00300;
    @(negedge clk);
    cmd_addr = 20'h00301;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    rvalid = 1'b1;
    rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_stale", 64'({rsp_valid, awvalid, wvalid, arvalid}), 64'(0));
      @(negedge clk);
    end
    run_txn(vecs[2]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
